// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM port arbiter: FSM state encoding,
// default burst length and beat counter sizing.
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_VID_CMD  = 3'd1,
        S_VID_DATA = 3'd2,
        S_CPU_CMD  = 3'd3,
        S_CPU_RD   = 3'd4,
        S_CPU_FIN  = 3'd5
    } arb_state_t;

    localparam int C_BURST_LEN_DEF = 8;

    // Width of a counter that indexes every beat of a burst (at least one bit).
    function automatic int beat_cnt_w(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/sdram_port_arbiter.sv
// Arbitrates the single SDRAM controller port between video bursts and CPU accesses.
// Optional CPU fairness (one video burst max wait) is enabled by defining SDRAM_ARB_FAIR_EN.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int C_addr_bits = 22,
    parameter int C_data_bits = 32,
    parameter int C_burst_len = C_BURST_LEN_DEF
) (
    input  logic                     clk_sdram,
    input  logic                     reset,
    input  logic                     vid_req,
    input  logic [C_addr_bits-1:0]   vid_addr,
    output logic                     vid_ack,
    output logic                     vid_valid,
    output logic [C_data_bits-1:0]   vid_data,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [C_addr_bits-1:0]   cpu_addr,
    input  logic [C_data_bits-1:0]   cpu_wdata,
    input  logic [C_data_bits/8-1:0] cpu_be,
    output logic [C_data_bits-1:0]   cpu_rdata,
    output logic                     cpu_done,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic                     mem_burst,
    output logic [C_addr_bits-1:0]   mem_addr,
    output logic [C_data_bits-1:0]   mem_wdata,
    output logic [C_data_bits/8-1:0] mem_be,
    input  logic                     mem_ack,
    input  logic                     mem_rvalid,
    input  logic [C_data_bits-1:0]   mem_rdata
);

    localparam int                    C_cnt_bits  = beat_cnt_w(C_burst_len);
    localparam logic [C_cnt_bits-1:0] C_last_beat = C_cnt_bits'(C_burst_len - 1);

    arb_state_t                r_state;
    arb_state_t                w_state_nxt;
    logic [C_cnt_bits-1:0]     r_beat;
    logic                      r_vid_ack;
    logic                      r_vid_valid;
    logic [C_data_bits-1:0]    r_vid_data;
    logic [C_data_bits-1:0]    r_cpu_rdata;
    logic                      r_cpu_done;
    logic                      r_mem_req;
    logic                      r_mem_we;
    logic                      r_mem_burst;
    logic [C_addr_bits-1:0]    r_mem_addr;
    logic [C_data_bits-1:0]    r_mem_wdata;
    logic [C_data_bits/8-1:0]  r_mem_be;
    logic                      w_cpu_elig;
    logic                      w_grant_vid;
    logic                      w_grant_cpu;

    // The requester drops cpu_req only in the cycle it sees cpu_done, so a
    // request still visible during that cycle is the one just completed.
`ifdef SDRAM_ARB_FAIR_EN
    logic r_last_was_vid;

    always_comb begin
        w_cpu_elig  = cpu_req && !r_cpu_done;
        w_grant_vid = vid_req && !(r_last_was_vid && w_cpu_elig);
        w_grant_cpu = w_cpu_elig && !w_grant_vid;
    end

    always_ff @(posedge clk_sdram or posedge reset) begin
        if (reset) begin
            r_last_was_vid <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (w_grant_vid)
                r_last_was_vid <= 1'b1;
            else if (w_grant_cpu)
                r_last_was_vid <= 1'b0;
        end
    end
`else
    always_comb begin
        w_cpu_elig  = cpu_req && !r_cpu_done;
        w_grant_vid = vid_req;
        w_grant_cpu = w_cpu_elig && !vid_req;
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_vid)
                    w_state_nxt = S_VID_CMD;
                else if (w_grant_cpu)
                    w_state_nxt = S_CPU_CMD;
            end
            S_VID_CMD:  if (mem_ack) w_state_nxt = S_VID_DATA;
            S_VID_DATA: if (mem_rvalid && r_beat == C_last_beat) w_state_nxt = S_IDLE;
            S_CPU_CMD:  if (mem_ack) w_state_nxt = r_mem_we ? S_CPU_FIN : S_CPU_RD;
            S_CPU_RD:   if (mem_rvalid) w_state_nxt = S_CPU_FIN;
            S_CPU_FIN:  w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sdram or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Command register, return-data mux and completion pulses.
    always_ff @(posedge clk_sdram or posedge reset) begin
        if (reset) begin
            r_beat      <= '0;
            r_vid_ack   <= 1'b0;
            r_vid_valid <= 1'b0;
            r_vid_data  <= '0;
            r_cpu_rdata <= '0;
            r_cpu_done  <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_burst <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
        end else begin
            r_vid_ack   <= 1'b0;
            r_vid_valid <= 1'b0;
            r_cpu_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vid) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_burst <= 1'b1;
                        r_mem_addr  <= vid_addr;
                        r_mem_wdata <= '0;
                        r_mem_be    <= '1;
                    end else if (w_grant_cpu) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= cpu_we;
                        r_mem_burst <= 1'b0;
                        r_mem_addr  <= cpu_addr;
                        r_mem_wdata <= cpu_wdata;
                        r_mem_be    <= cpu_be;
                    end
                end
                S_VID_CMD: begin
                    if (mem_ack) begin
                        r_vid_ack <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_beat    <= '0;
                    end
                end
                S_VID_DATA: begin
                    if (mem_rvalid) begin
                        r_vid_valid <= 1'b1;
                        r_vid_data  <= mem_rdata;
                        r_beat      <= r_beat + C_cnt_bits'(1);
                    end
                end
                S_CPU_CMD: if (mem_ack) r_mem_req <= 1'b0;
                S_CPU_RD:  if (mem_rvalid) r_cpu_rdata <= mem_rdata;
                S_CPU_FIN: r_cpu_done <= 1'b1;
                default: ;
            endcase
        end
    end

    assign vid_ack   = r_vid_ack;
    assign vid_valid = r_vid_valid;
    assign vid_data  = r_vid_data;
    assign cpu_rdata = r_cpu_rdata;
    assign cpu_done  = r_cpu_done;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_burst = r_mem_burst;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed self-checking bench for sdram_port_arbiter; grant-order expectations
// follow SDRAM_ARB_FAIR_EN when it is defined for the build.
module tb_sdram_port_arbiter;

    localparam int AW = 22;
    localparam int DW = 32;
    localparam int BL = 8;

    logic            clk_sdram = 1'b0;
    logic            reset     = 1'b1;
    logic            vid_req   = 1'b0;
    logic [AW-1:0]   vid_addr  = '0;
    logic            vid_ack;
    logic            vid_valid;
    logic [DW-1:0]   vid_data;
    logic            cpu_req   = 1'b0;
    logic            cpu_we    = 1'b0;
    logic [AW-1:0]   cpu_addr  = '0;
    logic [DW-1:0]   cpu_wdata = '0;
    logic [DW/8-1:0] cpu_be    = '0;
    logic [DW-1:0]   cpu_rdata;
    logic            cpu_done;
    logic            mem_req;
    logic            mem_we;
    logic            mem_burst;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic            mem_ack    = 1'b0;
    logic            mem_rvalid = 1'b0;
    logic [DW-1:0]   mem_rdata  = '0;

    int n_vec = 0;
    int n_err = 0;

    sdram_port_arbiter #(
        .C_addr_bits (AW),
        .C_data_bits (DW),
        .C_burst_len (BL)
    ) dut (
        .clk_sdram  (clk_sdram),
        .reset      (reset),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_ack    (vid_ack),
        .vid_valid  (vid_valid),
        .vid_data   (vid_data),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_be     (cpu_be),
        .cpu_rdata  (cpu_rdata),
        .cpu_done   (cpu_done),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_burst  (mem_burst),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk_sdram = ~clk_sdram;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sdram);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vid_ack"},   vid_ack,   0);
        chk({tag, "_vid_valid"}, vid_valid, 0);
        chk({tag, "_vid_data"},  vid_data,  0);
        chk({tag, "_cpu_done"},  cpu_done,  0);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
        chk({tag, "_mem_req"},   mem_req,   0);
        chk({tag, "_mem_we"},    mem_we,    0);
        chk({tag, "_mem_burst"}, mem_burst, 0);
        chk({tag, "_mem_addr"},  mem_addr,  0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_mem_be"},    mem_be,    0);
    endtask

    // Waits (bounded) for a command to appear; returns 1 for video, 0 for CPU.
    task automatic wait_grant(input string tag, output logic is_vid);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_req) break;
        end
        chk({tag, "_mem_req"}, mem_req, 1);
        is_vid = mem_burst;
    endtask

    // Accepts the pending video command and returns a full burst base..base+BL-1.
    task automatic serve_vid(input string tag, input logic [DW-1:0] base);
        mem_ack = 1'b1;
        tick();
        chk({tag, "_vid_ack"}, vid_ack, 1);
        chk({tag, "_req_low"}, mem_req, 0);
        mem_ack = 1'b0;
        vid_req = 1'b0;
        for (int i = 0; i < BL; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = base + DW'(i);
            tick();
            chk({tag, "_beat_valid"}, vid_valid, 1);
            chk({tag, "_beat_data"},  vid_data,  base + DW'(i));
            if (i == 0) chk({tag, "_ack_pulse"}, vid_ack, 0);
        end
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    // Accepts the pending CPU write and checks the completion pulse timing.
    task automatic serve_cpu_wr(input string tag);
        mem_ack = 1'b1;
        tick();
        chk({tag, "_req_low"}, mem_req, 0);
        chk({tag, "_done_early"}, cpu_done, 0);
        mem_ack = 1'b0;
        tick();
        chk({tag, "_done"}, cpu_done, 1);
        cpu_req = 1'b0;
        tick();
        chk({tag, "_done_pulse"}, cpu_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic g1, g2, g3, gv;

        // Reset state
        tick();
        tick();
        chk_all_zero("rst");
        reset = 1'b0;
        tick();
        chk("rst_idle_req", mem_req, 0);

        // Video burst, controller acks on the third command cycle
        vid_req  = 1'b1;
        vid_addr = 22'h000100;
        tick();
        chk("vA_req",   mem_req,   1);
        chk("vA_burst", mem_burst, 1);
        chk("vA_we",    mem_we,    0);
        chk("vA_be",    mem_be,    4'hF);
        chk("vA_addr",  mem_addr,  22'h000100);
        chk("vA_ack0",  vid_ack,   0);
        tick();
        tick();
        chk("vA_hold_req",  mem_req,  1);
        chk("vA_hold_addr", mem_addr, 22'h000100);
        serve_vid("vA", 32'hA0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hEE;
        tick();
        chk("vA_stray_valid", vid_valid, 0);
        chk("vA_stray_data",  vid_data,  32'hA7);
        chk("vA_idle_req",    mem_req,   0);
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        // CPU write
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 22'h001234;
        cpu_wdata = 32'hDEADBEEF;
        cpu_be    = 4'h3;
        tick();
        chk("wr_req",   mem_req,   1);
        chk("wr_we",    mem_we,    1);
        chk("wr_burst", mem_burst, 0);
        chk("wr_addr",  mem_addr,  22'h001234);
        chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
        chk("wr_be",    mem_be,    4'h3);
        serve_cpu_wr("wr");

        // CPU read
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 22'h000042;
        tick();
        chk("rd_req",   mem_req,   1);
        chk("rd_we",    mem_we,    0);
        chk("rd_burst", mem_burst, 0);
        chk("rd_addr",  mem_addr,  22'h000042);
        mem_ack = 1'b1;
        tick();
        chk("rd_req_low", mem_req, 0);
        mem_ack = 1'b0;
        tick();
        chk("rd_wait_done", cpu_done, 0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55AA55AA;
        tick();
        chk("rd_done_early", cpu_done, 0);
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0BADF00D;
        tick();
        chk("rd_done",  cpu_done,  1);
        chk("rd_rdata", cpu_rdata, 32'h55AA55AA);
        cpu_req = 1'b0;
        tick();
        chk("rd_done_pulse", cpu_done,  0);
        chk("rd_rdata_hold", cpu_rdata, 32'h55AA55AA);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12345678;
        tick();
        chk("rd_stray_rdata", cpu_rdata, 32'h55AA55AA);
        chk("rd_stray_vid",   vid_valid, 0);
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        // Simultaneous requests twice in a row
        vid_req   = 1'b1;
        vid_addr  = 22'h000200;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 22'h000077;
        cpu_wdata = 32'h00000011;
        cpu_be    = 4'hF;
        wait_grant("g1", g1);
        if (g1) serve_vid("g1v", 32'hC0); else serve_cpu_wr("g1c");
        vid_req  = 1'b1;
        vid_addr = 22'h000300;
        wait_grant("g2", g2);
        if (g2) serve_vid("g2v", 32'hD0); else serve_cpu_wr("g2c");
        wait_grant("g3", g3);
        if (g3) serve_vid("g3v", 32'hE0); else serve_cpu_wr("g3c");
`ifdef SDRAM_ARB_FAIR_EN
        chk("order_g1", g1, 1);
        chk("order_g2", g2, 0);
        chk("order_g3", g3, 1);
`else
        chk("order_g1", g1, 1);
        chk("order_g2", g2, 1);
        chk("order_g3", g3, 0);
`endif
        vid_req = 1'b0;
        cpu_req = 1'b0;
        tick();
        tick();

        // Reset during beat 4 of a video burst, stray data afterwards
        vid_req  = 1'b1;
        vid_addr = 22'h000400;
        wait_grant("rb", gv);
        chk("rb_is_vid", gv, 1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        vid_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hB0 + DW'(i);
            tick();
        end
        chk("rb_pre_data", vid_data, 32'hB3);
        mem_rdata = 32'hB4;
        reset     = 1'b1;
        #1;
        chk_all_zero("rb_async");
        tick();
        tick();
        chk("rb_in_rst_valid", vid_valid, 0);
        reset     = 1'b0;
        mem_rdata = 32'hB5;
        tick();
        chk("rb_stray_valid", vid_valid, 0);
        chk("rb_stray_data",  vid_data,  0);
        chk("rb_stray_req",   mem_req,   0);
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        // CPU read served normally after the aborted burst
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 22'h000099;
        tick();
        chk("pr_req",   mem_req,   1);
        chk("pr_burst", mem_burst, 0);
        chk("pr_addr",  mem_addr,  22'h000099);
        mem_ack = 1'b1;
        tick();
        mem_ack    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE0001;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        tick();
        chk("pr_done",  cpu_done,  1);
        chk("pr_rdata", cpu_rdata, 32'hCAFE0001);
        cpu_req = 1'b0;
        tick();
        chk("pr_done_pulse", cpu_done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Shares the single 100 MHz SDRAM controller port between the video line fetcher and the RISC5 CPU memory bus. It runs in the clk_sdram domain, in front of the SDRAM controller inside RISC5Top. It issues 8-word video read bursts and single-word CPU reads and writes, and routes returned data back to the requester that issued the command. Video has priority so the display never underruns. CPU starvation is bounded by an optional fairness rule.

## Interface
Parameters:
- C_addr_bits, 22: word address width.
- C_data_bits, 32: data word width.
- C_burst_len, 8: words per video burst, power of two.

Ports:
- clk_sdram, in, 1: sole clock.
- reset, in, 1: asynchronous, active-high reset.
- vid_req, in, 1: level request for a burst; held until vid_ack.
- vid_addr, in, C_addr_bits: burst start address, aligned to C_burst_len.
- vid_ack, out, 1: one-cycle pulse when the controller accepts the video command.
- vid_valid, out, 1: strobe for each returned video word.
- vid_data, out, C_data_bits: returned video word.
- cpu_req, in, 1: level request; held until cpu_done.
- cpu_we, in, 1: 1 for write, 0 for read.
- cpu_addr, in, C_addr_bits: CPU word address.
- cpu_wdata, in, C_data_bits: CPU write data.
- cpu_be, in, C_data_bits/8: CPU byte enables.
- cpu_rdata, out, C_data_bits: read data; held until the next CPU read completes.
- cpu_done, out, 1: one-cycle completion pulse.
- mem_req, out, 1: command valid to the controller.
- mem_we, mem_burst, out, 1 each: write flag; burst-read flag.
- mem_addr, mem_wdata, mem_be, out: command fields.
- mem_ack, in, 1: controller accepted the command this cycle.
- mem_rvalid, in, 1: read data strobe.
- mem_rdata, in, C_data_bits: read data.

## Operation
- States:
  - IDLE
  - VID_CMD
  - VID_DATA
  - CPU_CMD
  - CPU_RD
  - CPU_FIN
- Transitions:
  - IDLE: vid_req wins over cpu_req, subject to the fairness rule under Configuration. The chosen command is registered onto the mem_* outputs and mem_req is set. The FSM moves to VID_CMD or CPU_CMD.
  - VID_CMD: hold mem_req and all command fields stable until mem_ack. On mem_ack, pulse vid_ack, clear mem_req, zero the beat counter, go to VID_DATA.
  - VID_DATA: each mem_rvalid drives vid_valid=1 with vid_data=mem_rdata and increments the counter. After beat C_burst_len-1, go to IDLE.
  - CPU_CMD: on mem_ack, clear mem_req. A write goes to CPU_FIN; a read goes to CPU_RD.
  - CPU_RD: the first mem_rvalid loads cpu_rdata, then the FSM goes to CPU_FIN.
  - CPU_FIN: pulse cpu_done, go to IDLE. The requester drops cpu_req in the same cycle it sees cpu_done. cpu_req is not re-sampled in this cycle.
- Request sampling: requests are sampled only in IDLE. Once a command is issued it always completes. Dropping a request after issue has no effect.
- Stray data: mem_rvalid outside VID_DATA and CPU_RD is ignored.
- Fixed controls: mem_burst=1 only for video commands. A video command always has mem_we=0 and mem_be all ones.

## Timing
- Reset values:
  - vid_ack, vid_valid, cpu_done, mem_req, mem_we, mem_burst: 0.
  - vid_data, cpu_rdata, mem_addr, mem_wdata, mem_be: 0.
  - FSM: IDLE; beat counter: 0.
- Reset mid-operation aborts the transaction immediately, and any data arriving afterwards is ignored.
- All outputs are registered, with no combinational path from input to output.
- Latencies:
  - req sampled in IDLE to mem_req high: 1 cycle.
  - mem_ack to vid_ack or mem_req low: same edge.
  - mem_rvalid to vid_valid: 1 cycle.
  - CPU read: last mem_rvalid to cpu_done, 2 cycles.
  - CPU write: mem_ack to cpu_done, 2 cycles.
- Minimum gap between consecutive commands: 1 IDLE cycle.
- The counter is $clog2(C_burst_len) bits and its wrap at the last beat is not used for control; the state exit is.

## Configuration
- Macro SDRAM_ARB_FAIR_EN.
- Defined: a one-bit last_was_vid flag is set by a video grant and cleared by a CPU grant. If both requests are present in IDLE and last_was_vid=1, the CPU is granted. The CPU therefore waits at most one video burst.
- Undefined: strict video priority and the flag is absent. The CPU is granted only when vid_req=0 in IDLE.

## Structure
- Shared package sdram_arb_pkg holds:
  - the state enum;
  - C_burst_len default;
  - beat counter width function.
- Single module, no sub-module: the FSM, command register and return mux are small and tightly coupled.

## Test plan
- Reset, then vid_req with vid_addr=0x000100; controller acks after 3 cycles and returns 8 beats 0xA0..0xA7 -> one vid_ack pulse, mem_burst=1, 8 vid_valid strobes in order, FSM back in IDLE.
- CPU write with cpu_addr=0x1234, cpu_wdata=0xDEADBEEF, cpu_be=0x3; ack after 1 cycle -> the mem_* fields match the inputs, and cpu_done pulses 2 cycles after mem_ack.
- CPU read at 0x0042, controller returns 0x55AA55AA -> cpu_rdata=0x55AA55AA when cpu_done pulses, held afterwards.
- vid_req and cpu_req raised in the same cycle twice in a row -> with SDRAM_ARB_FAIR_EN the order is video, CPU, video. Without it, video is served twice while the CPU waits.
- reset asserted during beat 4 of a video burst, with stray mem_rvalid afterwards -> all outputs 0, no vid_valid, FSM in IDLE; the next cpu_req is served normally.
